switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 5: number of switch inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz): stable-level qualification time in clocks; legal range 2..2^20.
REQ-003 clk_clk  input  1: sole clock; all logic on its rising edge.
REQ-004 reset_reset  input  1: reset, synchronous, active-high.
REQ-005 switches_in  input  WIDTH: raw asynchronous board switch levels.
REQ-006 switches_stable  output  WIDTH: debounced level per switch; drives the switches PIO export.
REQ-007 change_valid  output  1: a debounced change snapshot is pending.
REQ-008 change_value  output  WIDTH: switches_stable captured at the most recent change event.
REQ-009 change_ack  input  1: consumer acknowledge of the pending snapshot.
REQ-010 overrun  output  1: sticky; a change event occurred while a snapshot was unacknowledged.
REQ-011 drop_count  output  8: count of overwritten snapshots (only meaningful with SWITCH_OVERRUN_EN).

Function
REQ-012 Each switches_in bit passes through a 2-flop synchronizer; logic downstream uses only the second flop (sync bit).
REQ-013 Per bit, an independent counter (width ceil(log2(DEBOUNCE_CYCLES))) clears to 0 whenever sync bit equals stable bit.
REQ-014 While sync bit differs from stable bit, the counter increments by 1 per clock.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, the stable bit takes the sync value next edge and the counter clears.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES clocks at the sync output leaves the stable bit unchanged and resets that bit's counter.
REQ-017 Latency: a clean input level change appears on switches_stable exactly DEBOUNCE_CYCLES+2 clocks after the first edge sampling the new level.
REQ-018 Change event: any stable bit updating in a cycle; several bits updating in the same cycle form one event.
REQ-019 Handshake FSM states EMPTY (change_valid=0) and PENDING (change_valid=1).
REQ-020 EMPTY + event -> PENDING; change_value loads the new stable vector.
REQ-021 PENDING + change_ack, no event -> EMPTY; change_value holds.
REQ-022 PENDING + change_ack + event same cycle -> stays PENDING with new value; no overrun.
REQ-023 PENDING + event, no ack -> stays PENDING; change_value replaced with newest vector; overrun event raised.
REQ-024 change_ack in EMPTY is ignored.
REQ-025 change_value is stable whenever change_valid=1 except on REQ-022/REQ-023 updates.

Reset
REQ-026 While reset_reset=1 at an edge: synchronizers, switches_stable, all counters, change_value, drop_count to 0; change_valid, overrun to 0; FSM to EMPTY.
REQ-027 Switches high at reset release debounce normally and produce a change event after DEBOUNCE_CYCLES+2 clocks.
REQ-028 Reset asserted mid-count aborts the count; no partial stable update.

Configuration
REQ-029 Macro SWITCH_OVERRUN_EN defined: overrun sets on REQ-023 and clears only on the cycle change_ack is accepted in PENDING; drop_count increments per overrun event, saturating at 255, cleared only by reset.
REQ-030 Macro SWITCH_OVERRUN_EN undefined: overrun and drop_count tied to 0; REQ-023 still replaces change_value.

Verification (DEBOUNCE_CYCLES=4, WIDTH=5)
REQ-031 switches_in 00000->00001 held -> switches_stable=00001 exactly 6 clocks later; change_valid=1, change_value=00001 same cycle.
REQ-032 bit 2 pulsed high 3 clocks then low -> switches_stable unchanged, change_valid stays 0.
REQ-033 bits 0 and 4 change same edge -> single event, change_value=10001; ack one cycle -> change_valid=0 next cycle.
REQ-034 two events 10 clocks apart, no ack -> change_value=second vector, overrun=1, drop_count=1 (macro on); overrun=0, drop_count=0 (macro off).
REQ-035 ack asserted in the cycle of a new event -> change_valid remains 1, new value loaded, overrun=0.
REQ-036 reset asserted 2 clocks into a count with input 11111 -> all outputs 0; after release, stable=11111 6 clocks later.

Source files
------------

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// switch_debouncer : per-bit 2-flop synchronizer and counter debounce feeding
//                    a one-deep change-snapshot handshake.
// Optional: define SWITCH_OVERRUN_EN for the sticky overrun flag/drop counter.
// Revision: 1.0
// ============================================================================

module switch_debouncer #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] switches_in,
  output logic [WIDTH-1:0] switches_stable,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_value,
  input  logic             change_ack,
  output logic             overrun,
  output logic [7:0]       drop_count
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] change_value_q, change_value_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  state_t           state_q, state_d;
  logic             change_event;

  // Debounce: each bit's counter runs only while the synchronized level
  // disagrees with the qualified level.
  always_comb begin
    sync1_d  = switches_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered export stage; events are detected here so the exported level
  // and the snapshot update on the same edge.
  always_comb begin
    out_d        = stable_q;
    change_event = (out_d != out_q);
  end

  always_comb begin
    state_d        = state_q;
    change_value_d = change_value_q;
    case (state_q)
      EMPTY: begin
        if (change_event) begin
          state_d        = PENDING;
          change_value_d = out_d;
        end
      end
      PENDING: begin
        if (change_event) begin
          change_value_d = out_d;
        end else if (change_ack) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      stable_q       <= '0;
      out_q          <= '0;
      change_value_q <= '0;
      cnt_q          <= '{default: '0};
      state_q        <= EMPTY;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      stable_q       <= stable_d;
      out_q          <= out_d;
      change_value_q <= change_value_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
    end
  end

  assign switches_stable = out_q;
  assign change_valid    = (state_q == PENDING);
  assign change_value    = change_value_q;

`ifdef SWITCH_OVERRUN_EN
  logic       overrun_q, overrun_d;
  logic [7:0] drop_count_q, drop_count_d;

  // An unacknowledged snapshot overwritten by a newer event is an overrun;
  // an ack in the same cycle as the event is a clean hand-over instead.
  always_comb begin
    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;
    if ((state_q == PENDING) && change_event && !change_ack) begin
      overrun_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end else if ((state_q == PENDING) && change_ack) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      overrun_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;
`else
  assign overrun    = 1'b0;
  assign drop_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// tb_switch_debouncer : scoreboard bench for switch_debouncer (WIDTH=5,
//                       DEBOUNCE_CYCLES=4).
// Revision: 1.0
// ============================================================================

module tb_switch_debouncer;

  localparam int W = 5;
  localparam int N = 4;
`ifdef SWITCH_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic         clk_clk = 1'b0;
  logic         reset_reset = 1'b1;
  logic [W-1:0] switches_in = '0;
  logic [W-1:0] switches_stable;
  logic         change_valid;
  logic [W-1:0] change_value;
  logic         change_ack = 1'b0;
  logic         overrun;
  logic [7:0]   drop_count;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_val;
  logic [7:0]   exp_drop = 8'd0;

  switch_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .switches_in    (switches_in),
    .switches_stable(switches_stable),
    .change_valid   (change_valid),
    .change_value   (change_value),
    .change_ack     (change_ack),
    .overrun        (overrun),
    .drop_count     (drop_count)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  // Pop the next expected snapshot; an empty scoreboard is itself an error.
  task automatic pop_expected();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected snapshot queued");
      exp_val = 'x;
    end else begin
      exp_val = exp_q.pop_front();
    end
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    switches_in = '0;
    change_ack  = 1'b0;
    tick(3);
    reset_reset = 1'b0;
    exp_drop    = 8'd0;
    exp_q.delete();
    tick(2);
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    switches_in = '0;
    tick(3);
    checks++; if (switches_stable !== 5'b00000) begin errors++; $display("FAIL reset_stable: got=%b exp=%b", switches_stable, 5'b00000); end
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got=%b exp=0", change_valid); end
    checks++; if (change_value !== 5'b00000) begin errors++; $display("FAIL reset_value: got=%b exp=%b", change_value, 5'b00000); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got=%b exp=0", overrun); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got=%0d exp=0", drop_count); end
    reset_reset = 1'b0;
    tick(2);
  endtask

  // Input driven before edge E0; the export must flip on E6, not E5.
  task automatic test_single_bit();
    switches_in = 5'b00001;
    exp_q.push_back(5'b00001);
    tick(6);
    checks++; if (switches_stable !== 5'b00000) begin errors++; $display("FAIL single_early: got=%b exp=%b", switches_stable, 5'b00000); end
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got=%b exp=0", change_valid); end
    tick(1);
    pop_expected();
    checks++; if (switches_stable !== 5'b00001) begin errors++; $display("FAIL single_stable: got=%b exp=%b", switches_stable, 5'b00001); end
    checks++; if (change_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got=%b exp=1", change_valid); end
    checks++; if (change_value !== exp_val) begin errors++; $display("FAIL single_value: got=%b exp=%b", change_value, exp_val); end
    change_ack = 1'b1;
    tick(1);
    change_ack = 1'b0;
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got=%b exp=0", change_valid); end
    checks++; if (change_value !== 5'b00001) begin errors++; $display("FAIL single_hold: got=%b exp=%b", change_value, 5'b00001); end
  endtask

  task automatic test_glitch();
    switches_in = 5'b00101;
    tick(3);
    switches_in = 5'b00001;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (switches_stable !== 5'b00001 || change_valid !== 1'b0) begin
        errors++; $display("FAIL glitch_cycle%0d: stable=%b valid=%b exp stable=%b valid=0", i, switches_stable, change_valid, 5'b00001);
      end
    end
  endtask

  task automatic test_multi_bit();
    do_reset();
    switches_in = 5'b10001;
    exp_q.push_back(5'b10001);
    tick(7);
    pop_expected();
    checks++; if (change_valid !== 1'b1) begin errors++; $display("FAIL multi_valid: got=%b exp=1", change_valid); end
    checks++; if (change_value !== exp_val) begin errors++; $display("FAIL multi_value: got=%b exp=%b", change_value, exp_val); end
    change_ack = 1'b1;
    tick(1);
    change_ack = 1'b0;
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL multi_ack: got=%b exp=0", change_valid); end
    tick(4);
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL multi_single_event: got=%b exp=0", change_valid); end
    change_ack = 1'b1;
    tick(1);
    change_ack = 1'b0;
    checks++; if (change_valid !== 1'b0 || change_value !== 5'b10001) begin
      errors++; $display("FAIL empty_ack_ignored: valid=%b value=%b exp valid=0 value=%b", change_valid, change_value, 5'b10001);
    end
  endtask

  task automatic test_overrun();
    switches_in = 5'b10011;
    exp_q.push_back(5'b10011);
    tick(7);
    pop_expected();
    checks++; if (change_valid !== 1'b1 || change_value !== exp_val) begin
      errors++; $display("FAIL ovr_first: valid=%b value=%b exp valid=1 value=%b", change_valid, change_value, exp_val);
    end
    tick(3);
    switches_in = 5'b11011;
    exp_q.push_back(5'b11011);
    if (OVR_EN) exp_drop = exp_drop + 8'd1;
    tick(7);
    pop_expected();
    checks++; if (change_value !== exp_val) begin errors++; $display("FAIL ovr_value: got=%b exp=%b", change_value, exp_val); end
    checks++; if (change_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got=%b exp=1", change_valid); end
    checks++; if (overrun !== OVR_EN) begin errors++; $display("FAIL ovr_flag: got=%b exp=%b", overrun, OVR_EN); end
    checks++; if (drop_count !== exp_drop) begin errors++; $display("FAIL ovr_drop: got=%0d exp=%0d", drop_count, exp_drop); end
    change_ack = 1'b1;
    tick(1);
    change_ack = 1'b0;
    checks++; if (change_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_ack: valid=%b overrun=%b exp both 0", change_valid, overrun);
    end
    checks++; if (drop_count !== exp_drop) begin errors++; $display("FAIL ovr_drop_hold: got=%0d exp=%0d", drop_count, exp_drop); end
  endtask

  // Second event lands on E9 while ack is held for exactly that edge.
  task automatic test_back_to_back();
    switches_in = 5'b11111;
    exp_q.push_back(5'b11111);
    tick(3);
    switches_in = 5'b01111;
    exp_q.push_back(5'b01111);
    tick(4);
    pop_expected();
    checks++; if (change_valid !== 1'b1 || change_value !== exp_val) begin
      errors++; $display("FAIL b2b_first: valid=%b value=%b exp valid=1 value=%b", change_valid, change_value, exp_val);
    end
    tick(2);
    change_ack = 1'b1;
    tick(1);
    change_ack = 1'b0;
    pop_expected();
    checks++; if (change_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got=%b exp=1", change_valid); end
    checks++; if (change_value !== exp_val) begin errors++; $display("FAIL b2b_value: got=%b exp=%b", change_value, exp_val); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got=%b exp=0", overrun); end
    checks++; if (drop_count !== exp_drop) begin errors++; $display("FAIL b2b_drop: got=%0d exp=%0d", drop_count, exp_drop); end
    change_ack = 1'b1;
    tick(1);
    change_ack = 1'b0;
  endtask

  task automatic test_reset_midcount();
    do_reset();
    switches_in = 5'b11111;
    tick(3);
    reset_reset = 1'b1;
    tick(2);
    exp_drop = 8'd0;
    checks++; if (switches_stable !== 5'b00000 || change_valid !== 1'b0 || change_value !== 5'b00000) begin
      errors++; $display("FAIL midreset_outputs: stable=%b valid=%b value=%b exp all 0", switches_stable, change_valid, change_value);
    end
    checks++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL midreset_ovr: overrun=%b drop=%0d exp 0/0", overrun, drop_count);
    end
    reset_reset = 1'b0;
    exp_q.push_back(5'b11111);
    tick(6);
    checks++; if (switches_stable !== 5'b00000) begin errors++; $display("FAIL midreset_early: got=%b exp=%b", switches_stable, 5'b00000); end
    tick(1);
    pop_expected();
    checks++; if (switches_stable !== 5'b11111) begin errors++; $display("FAIL midreset_stable: got=%b exp=%b", switches_stable, 5'b11111); end
    checks++; if (change_valid !== 1'b1 || change_value !== exp_val) begin
      errors++; $display("FAIL midreset_event: valid=%b value=%b exp valid=1 value=%b", change_valid, change_value, exp_val);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_glitch();
    test_multi_bit();
    test_overrun();
    test_back_to_back();
    test_reset_midcount();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
